// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the fetch/data memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'd0,
    MEM_SIZE_HALF = 2'd1,
    MEM_SIZE_WORD = 2'd2
  } mem_size_t;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    BUS_IF,
    BUS_D,
    ERR_RSP
  } arb_state_t;

  typedef enum logic {
    SRC_IF,
    SRC_D
  } arb_src_t;

  // Byte accesses are never misaligned; size 3 is not a legal decode and is left unchecked.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == MEM_SIZE_HALF) && addr_lo[0]) ||
           ((size == MEM_SIZE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_port_arbiter_timeout_counter.sv
// rtl/mem_port_arbiter_timeout_counter.sv - bus-busy watchdog for the memory port arbiter
module arb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_count;

  // Expires during the TIMEOUT_CYCLES-th stalled cycle so the bus command ends on that edge.
  assign o_expired = i_enable && (r_count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the single-ported memory bus between fetch and load/store
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_D_CONSEC   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_r_w,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_valid,
  output logic              mem_r_w,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CW = $clog2(MAX_D_CONSEC + 1);

  arb_state_t        r_state;
  arb_src_t          r_src;
  logic              r_mem_valid;
  logic              r_mem_r_w;
  logic [1:0]        r_mem_size;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [CW-1:0]     r_d_consec;
  logic              r_if_done, r_if_err, r_d_done, r_d_err;
  logic [DATA_W-1:0] r_if_rdata, r_d_rdata;

  logic              w_idle, w_bus, w_d_gnt, w_if_gnt, w_misaligned, w_expired;
  logic              w_fin_bus, w_fin, w_fin_err;
  logic [1:0]        w_gnt_size;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic [DATA_W-1:0] w_fin_data;

  assign w_idle   = (r_state == IDLE);
  assign w_bus    = (r_state == BUS_IF) || (r_state == BUS_D);
  // Data normally wins; a saturated run of data grants yields to a waiting fetch.
  assign w_d_gnt  = w_idle && d_req && !(if_req && (r_d_consec == CW'(MAX_D_CONSEC)));
  assign w_if_gnt = w_idle && if_req && !w_d_gnt;

  assign w_gnt_size   = w_d_gnt ? d_size : MEM_SIZE_WORD;
  assign w_gnt_addr   = w_d_gnt ? d_addr : if_addr;
  assign w_misaligned = is_misaligned(w_gnt_size, w_gnt_addr[1:0]);

  arb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_d_gnt || w_if_gnt),
    .i_enable (w_bus && !mem_ready),
    .o_expired(w_expired)
  );

  // A ready in the expiry cycle wins over the timeout.
  assign w_fin_bus  = w_bus && (mem_ready || w_expired);
  assign w_fin      = w_fin_bus || (r_state == ERR_RSP);
  assign w_fin_err  = !w_fin_bus || !mem_ready;
  assign w_fin_data = (w_fin_bus && mem_ready && (r_mem_r_w == MEM_READ)) ? mem_rdata : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_src       <= SRC_IF;
      r_mem_valid <= 1'b0;
      r_mem_r_w   <= MEM_READ;
      r_mem_size  <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_d_gnt || w_if_gnt) begin
            r_src       <= w_d_gnt ? SRC_D : SRC_IF;
            r_mem_r_w   <= w_d_gnt ? d_r_w : MEM_READ;
            r_mem_size  <= w_gnt_size;
            r_mem_addr  <= w_gnt_addr;
            r_mem_wdata <= w_d_gnt ? d_wdata : '0;
            if (w_misaligned) begin
              r_state <= ERR_RSP;
            end else begin
              r_state     <= w_d_gnt ? BUS_D : BUS_IF;
              r_mem_valid <= 1'b1;
            end
          end
        end
        BUS_IF, BUS_D: begin
          if (w_fin_bus) begin
            r_state     <= IDLE;
            r_mem_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_if_done  <= 1'b0;
      r_if_err   <= 1'b0;
      r_if_rdata <= '0;
      r_d_done   <= 1'b0;
      r_d_err    <= 1'b0;
      r_d_rdata  <= '0;
    end else begin
      r_if_done <= w_fin && (r_src == SRC_IF);
      r_d_done  <= w_fin && (r_src == SRC_D);
      if (w_fin && (r_src == SRC_IF)) begin
        r_if_err   <= w_fin_err;
        r_if_rdata <= w_fin_data;
      end
      if (w_fin && (r_src == SRC_D)) begin
        r_d_err   <= w_fin_err;
        r_d_rdata <= w_fin_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_d_consec <= '0;
    end else if (w_if_gnt) begin
      r_d_consec <= '0;
    end else if (w_d_gnt && if_req && (r_d_consec != CW'(MAX_D_CONSEC))) begin
      r_d_consec <= r_d_consec + CW'(1);
    end
  end

  assign if_gnt    = w_if_gnt;
  assign d_gnt     = w_d_gnt;
  assign if_done   = r_if_done;
  assign if_err    = r_if_err;
  assign if_rdata  = r_if_rdata;
  assign d_done    = r_d_done;
  assign d_err     = r_d_err;
  assign d_rdata   = r_d_rdata;
  assign mem_valid = r_mem_valid;
  assign mem_r_w   = r_mem_r_w;
  assign mem_size  = r_mem_size;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = !w_idle;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported memory bus between the instruction fetch path and the load/store data path of the RV32 core, so the core can run as a multi-cycle machine over one bus.
- Arbitrates between the two requesters, issues a held valid/ready bus transaction, detects misalignment and bus timeouts, and returns a registered completion to the requester.
- Sits between fetch/decode-driven memory controls (r/w, access size) and the external memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 255, bus-busy cycles before a transaction is aborted with error; must be ≥1.
- MAX_D_CONSEC, 4, consecutive data grants allowed while fetch is pending before fetch is forced.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch accepted, 1-cycle pulse.
- if_done  out  1  fetch complete, 1-cycle pulse.
- if_rdata  out  DATA_W  fetched instruction; valid with if_done.
- if_err  out  1  misaligned or timeout; valid with if_done.
- d_req  in  1  data request; held until d_gnt.
- d_r_w  in  1  1 = read, 0 = write (decode convention).
- d_size  in  2  0 = byte, 1 = half, 2 = word (funct3[1:0]).
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt, d_done, d_rdata, d_err  out  1/1/DATA_W/1  as for fetch.
- mem_valid  out  1  bus command valid.
- mem_r_w  out  1  bus direction.
- mem_size  out  2  bus access size.
- mem_addr  out  ADDR_W  bus address.
- mem_wdata  out  DATA_W  bus write data.
- mem_ready  in  1  bus completes the current command.
- mem_rdata  in  DATA_W  bus read data, valid with mem_ready.
- busy  out  1  high whenever state ≠ IDLE; feeds the core stall.

Behaviour:
- States: IDLE, BUS_IF, BUS_D, ERR_RSP.
- Reset (reset = 0, asynchronous):
  - state = IDLE; all outputs 0 except mem_r_w = 1.
  - Consecutive-data counter and timeout counter = 0.
  - Reset mid-transaction drops mem_valid immediately and issues no done pulse.
- Arbitration happens only in IDLE. Grant is combinational in the same cycle:
  - Data wins if d_req, unless if_req is also asserted and the consecutive-data counter = MAX_D_CONSEC.
  - Otherwise fetch wins if if_req.
  - At most one of if_gnt/d_gnt per cycle.
  - Counter rules: increments on a data grant while if_req = 1; clears on any fetch grant; saturates at MAX_D_CONSEC.
- On grant, the command (addr, r_w, size, wdata, source) is registered. A fetch is always a word read.
- Alignment check at grant:
  - Misaligned: half with addr[0] = 1, or word with addr[1:0] ≠ 0 (fetch included).
  - Misaligned requests go to ERR_RSP with no bus access.
  - ERR_RSP lasts one cycle, then IDLE. The done pulse is raised in the cycle after ERR_RSP with err = 1 and rdata = 0.
- BUS_IF/BUS_D:
  - mem_valid = 1 and command outputs stable from the cycle after grant until mem_ready is sampled high.
  - On mem_ready: capture mem_rdata (writes capture 0), return to IDLE.
  - The selected done is pulsed the next cycle with err = 0; rdata holds until the next done of that source.
- Latency: grant at cycle N, mem_valid at N+1, mem_ready at cycle M ≥ N+1, done at M+1.
  - Next arbitration is at M+1, giving one idle bubble between bus commands.
- Timeout:
  - Counter resets on grant and increments every busy cycle without mem_ready.
  - When it reaches TIMEOUT_CYCLES: drop mem_valid, go to IDLE, pulse done next cycle with err = 1 and rdata = 0.
  - mem_ready in the same cycle as timeout expiry counts as success.
- Requests asserted outside IDLE are ignored until IDLE; requesters hold them.
- Request-signal changes after grant have no effect on the in-flight command.
- busy = (state ≠ IDLE).

Decomposition:
- Shared package:
  - mem_size_t with MEM_SIZE_BYTE/HALF/WORD, matching the decode encoding.
  - MEM_READ = 1 / MEM_WRITE = 0.
  - arb_state_t enum.
  - arb_src_t (SRC_IF, SRC_D).
- One natural sub-module: arb_timeout_counter (clear, enable, expired flag, TIMEOUT_CYCLES parameter).

Test Plan:
- Fetch alone: if_req with if_addr = 0x100; mem_ready 3 cycles after mem_valid, mem_rdata = 0x00500093 -> if_gnt in cycle 0; mem_addr = 0x100, mem_size = 2, mem_r_w = 1; if_done with if_rdata = 0x00500093, if_err = 0 one cycle after ready.
- Simultaneous if_req and d_req (read, word, 0x2000), MAX_D_CONSEC = 4 -> d_gnt first; if_gnt in the IDLE cycle after d_done.
- d_req and if_req held continuously, zero-wait memory -> exactly 4 data grants, then 1 fetch grant, and the pattern repeats.
- Store of half to 0x2001 -> d_gnt, no mem_valid ever, d_done with d_err = 1 two cycles after grant.
- TIMEOUT_CYCLES = 8, mem_ready held low -> mem_valid high for exactly 8 cycles, then d_done with d_err = 1 and d_rdata = 0; busy then falls.
- reset asserted (driven 0) while mem_valid = 1 -> mem_valid, busy, and done outputs fall without a clock edge; after release, a new fetch completes normally.
